// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard control unit.
// Holds the hazard FSM state encoding and the operand-forwarding select codes.
// No logic; imported by the forwarding comparator and the top.
package hazard_pkg;

    // Hazard FSM states: normal flow, load-use bubble, post-branch IF/ID flush
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Operand source selects driven to the EX-stage operand muxes
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/fwd_select.sv
// Forwarding comparator for one ID-stage source operand.
// Purely combinational, zero latency.
// No flow control; the select follows the pipeline stage registers directly.
module fwd_select
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] src_reg,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  wb_reg_write,
    output logic [1:0]            fwd
);

    // MEM holds the younger result, so it wins over WB; register 0 is never forwarded
    always_comb begin
        fwd = FWD_RF;
        if (mem_reg_write && (mem_rd != '0) && (mem_rd == src_reg)) begin
            fwd = FWD_MEM;
        end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == src_reg)) begin
            fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard control: load-use stalls, branch flushes, operand forwarding.
// Control outputs react in the same cycle; stall/flush sequencing is held in the FSM.
// A taken branch overrides any stall; reset drops any in-progress stall or flush.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W        = 5,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES      = 1,
    parameter int CNT_W             = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_rs_used,
    input  logic                  id_rt_used,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  wb_reg_write,
    input  logic                  branch_taken,
    output logic                  pc_write_en,
    output logic                  ifid_write_en,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic                  stall_active,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_events
);

    state_t           state_q, state_d;
    logic [1:0]       count_q, count_d;
    logic [CNT_W-1:0] stall_cycles_q, flush_events_q;
    logic             load_use;
    logic             bubble;
    logic             pc_we_c, ifid_we_c, ifid_flush_c, idex_flush_c;

    // A load's result only exists after MEM, so a dependent ID instruction must wait
    assign load_use = ex_mem_read && (ex_rd != '0) &&
                      ((id_rs_used && (ex_rd == id_rs)) ||
                       (id_rt_used && (ex_rd == id_rt)));

    // Every stage writes registers through WB, so the EX write flag adds nothing here
    logic unused_ex_reg_write;
    assign unused_ex_reg_write = ex_reg_write;

    // Next-state and same-cycle control decode; branch overrides everything
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        pc_we_c      = 1'b1;
        ifid_we_c    = 1'b1;
        ifid_flush_c = 1'b0;
        idex_flush_c = 1'b0;
        bubble       = 1'b0;
        if (branch_taken) begin
            ifid_flush_c = 1'b1;
            idex_flush_c = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_d = FLUSH;
                count_d = 2'(FLUSH_CYCLES - 1);
            end else begin
                state_d = RUN;
                count_d = 2'd0;
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (load_use) begin
                        pc_we_c      = 1'b0;
                        ifid_we_c    = 1'b0;
                        idex_flush_c = 1'b1;
                        bubble       = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            state_d = STALL;
                            count_d = 2'(LOAD_STALL_CYCLES - 1);
                        end
                    end
                end
                STALL: begin
                    pc_we_c      = 1'b0;
                    ifid_we_c    = 1'b0;
                    idex_flush_c = 1'b1;
                    bubble       = 1'b1;
                    if (count_q <= 2'd1) begin
                        state_d = RUN;
                        count_d = 2'd0;
                    end else begin
                        count_d = count_q - 2'd1;
                    end
                end
                FLUSH: begin
                    ifid_flush_c = 1'b1;
                    if (count_q <= 2'd1) begin
                        state_d = RUN;
                        count_d = 2'd0;
                    end else begin
                        count_d = count_q - 2'd1;
                    end
                end
                default: begin
                    state_d = RUN;
                    count_d = 2'd0;
                end
            endcase
        end
    end

    // FSM state and remaining-cycle count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            count_q <= 2'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Saturating performance counters: stall bubbles and taken branches
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            if (bubble && (stall_cycles_q != '1)) begin
                stall_cycles_q <= stall_cycles_q + CNT_W'(1);
            end
            if (branch_taken && (flush_events_q != '1)) begin
                flush_events_q <= flush_events_q + CNT_W'(1);
            end
        end
    end

    // Reset forces the pass-through control values even if the inputs show a hazard
    assign pc_write_en   = rst | pc_we_c;
    assign ifid_write_en = rst | ifid_we_c;
    assign ifid_flush    = ~rst & ifid_flush_c;
    assign idex_flush    = ~rst & idex_flush_c;
    assign stall_active  = (state_q != RUN);
    assign stall_cycles  = stall_cycles_q;
    assign flush_events  = flush_events_q;

    fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
        .src_reg       (id_rs),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .fwd           (fwd_a)
    );

    fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
        .src_reg       (id_rt),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .fwd           (fwd_b)
    );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: three instances with different stall/flush/counter
// parameters share one stimulus; a remaining-work model predicts every output.
module tb_hazard_ctrl_unit;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rd, mem_rd, wb_rd;
    logic       id_rs_used, id_rt_used, ex_reg_write, ex_mem_read;
    logic       mem_reg_write, wb_reg_write, branch_taken;

    logic        pc_o[3], ifid_o[3], ifidf_o[3], idexf_o[3], sa_o[3];
    logic [1:0]  fa_o[3], fb_o[3];
    logic [15:0] sc_o[3], fe_o[3];

    // Instance 0: LSC=2 FC=2 CNT_W=16; 1: LSC=1 FC=1 CNT_W=4; 2: LSC=3 FC=1 CNT_W=16
    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LSC = (g == 0) ? 2 : (g == 1) ? 1 : 3;
        localparam int FC  = (g == 0) ? 2 : 1;
        localparam int CW  = (g == 1) ? 4 : 16;
        logic [CW-1:0] sc_w, fe_w;
        hazard_ctrl_unit #(
            .REG_ADDR_W(5), .LOAD_STALL_CYCLES(LSC), .FLUSH_CYCLES(FC), .CNT_W(CW)
        ) u_dut (
            .clk(clk), .rst(rst),
            .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
            .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
            .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
            .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
            .branch_taken(branch_taken),
            .pc_write_en(pc_o[g]), .ifid_write_en(ifid_o[g]),
            .ifid_flush(ifidf_o[g]), .idex_flush(idexf_o[g]),
            .fwd_a(fa_o[g]), .fwd_b(fb_o[g]),
            .stall_active(sa_o[g]),
            .stall_cycles(sc_w), .flush_events(fe_w)
        );
        assign sc_o[g] = 16'(sc_w);
        assign fe_o[g] = 16'(fe_w);
    end

    int errors = 0;
    int checks = 0;

    // ---------------- reference model ----------------
    int P_LSC[3] = '{2, 1, 3};
    int P_FC[3]  = '{2, 1, 1};
    int P_MAX[3] = '{65535, 15, 65535};
    int m_stall[3];   // bubbles still owed after the current cycle
    int m_flush[3];   // flush cycles still owed
    int m_sc[3];
    int m_fe[3];

    function automatic logic [4:0] ctl(int i);
        return {pc_o[i], ifid_o[i], ifidf_o[i], idexf_o[i], sa_o[i]};
    endfunction

    function automatic bit hazard_now();
        return ex_mem_read && (ex_rd != 0) &&
               ((id_rs_used && ex_rd == id_rs) || (id_rt_used && ex_rd == id_rt));
    endfunction

    // Expected {pc_we, ifid_we, ifid_flush, idex_flush, stall_active}
    function automatic logic [4:0] exp_ctl(int i);
        bit busy;
        busy = (m_stall[i] > 0) || (m_flush[i] > 0);
        if (rst)               return 5'b11000;
        if (branch_taken)      return {4'b1111, busy};
        if (m_flush[i] > 0)    return 5'b11101;
        if (m_stall[i] > 0)    return 5'b00011;
        if (hazard_now())      return 5'b00010;
        return 5'b11000;
    endfunction

    function automatic logic [1:0] exp_fwd(logic [4:0] r);
        if (mem_reg_write && mem_rd != 0 && mem_rd == r) return 2'b10;
        if (wb_reg_write && wb_rd != 0 && wb_rd == r)    return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_stall[i] = 0; m_flush[i] = 0; m_sc[i] = 0; m_fe[i] = 0;
            end else if (branch_taken) begin
                m_stall[i] = 0;
                m_flush[i] = P_FC[i] - 1;
                if (m_fe[i] < P_MAX[i]) m_fe[i]++;
            end else if (m_flush[i] > 0) begin
                m_flush[i]--;
            end else if (m_stall[i] > 0) begin
                m_stall[i]--;
                if (m_sc[i] < P_MAX[i]) m_sc[i]++;
            end else if (hazard_now()) begin
                m_stall[i] = P_LSC[i] - 1;
                if (m_sc[i] < P_MAX[i]) m_sc[i]++;
            end
        end
    endtask

    // Advance one clock; return 1 time unit after the falling edge
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0;
        ex_rd = 0; ex_reg_write = 0; ex_mem_read = 0;
        mem_rd = 0; mem_reg_write = 0; wb_rd = 0; wb_reg_write = 0;
        branch_taken = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        #1;
        cycle();
        rst = 0;
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1;
        idle_inputs();
        ex_mem_read = 1; ex_rd = 4; id_rs = 4; id_rs_used = 1;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ctl(i) !== 5'b11000) begin
                errors++;
                $display("FAIL reset_ctl inst%0d: got %b expected 11000", i, ctl(i));
            end
            checks++;
            if (sc_o[i] !== 16'd0 || fe_o[i] !== 16'd0) begin
                errors++;
                $display("FAIL reset_cnt inst%0d: got sc=%0d fe=%0d expected 0/0", i, sc_o[i], fe_o[i]);
            end
        end
        cycle();
        rst = 0;
        idle_inputs();
        #1;
    endtask

    task automatic test_load_use();
        logic [4:0] exp;
        idle_inputs();
        ex_mem_read = 1; ex_rd = 8; id_rs = 8; id_rs_used = 1;
        #1;
        for (int c = 0; c < 2; c++) begin
            exp = (c == 0) ? 5'b00010 : 5'b00011;
            checks++;
            if (ctl(0) !== exp) begin
                errors++;
                $display("FAIL load_use_c%0d: got %b expected %b", c, ctl(0), exp);
            end
            cycle();
        end
        ex_mem_read = 0;
        #1;
        checks++;
        if (ctl(0) !== 5'b11000) begin
            errors++;
            $display("FAIL load_use_release: got %b expected 11000", ctl(0));
        end
        checks++;
        if (sc_o[0] !== 16'd2) begin
            errors++;
            $display("FAIL load_use_count: got %0d expected 2", sc_o[0]);
        end
        checks++;
        if (ctl(2) !== 5'b00011) begin
            errors++;
            $display("FAIL load_use_lsc3_third: got %b expected 00011", ctl(2));
        end
        repeat (2) cycle();
        checks++;
        if (sc_o[2] !== 16'd3) begin
            errors++;
            $display("FAIL load_use_lsc3_count: got %0d expected 3", sc_o[2]);
        end
    endtask

    task automatic test_branch_in_stall();
        do_reset();
        ex_mem_read = 1; ex_rd = 8; id_rs = 8; id_rs_used = 1;
        #1;
        checks++;
        if (ctl(0) !== 5'b00010) begin
            errors++;
            $display("FAIL bis_first: got %b expected 00010", ctl(0));
        end
        cycle();
        branch_taken = 1;
        #1;
        checks++;
        if (ctl(0) !== 5'b11111) begin
            errors++;
            $display("FAIL bis_branch: got %b expected 11111", ctl(0));
        end
        cycle();
        branch_taken = 0; ex_mem_read = 0;
        #1;
        checks++;
        if (ctl(0) !== 5'b11101) begin
            errors++;
            $display("FAIL bis_flush: got %b expected 11101", ctl(0));
        end
        checks++;
        if (fe_o[0] !== 16'd1 || sc_o[0] !== 16'd1) begin
            errors++;
            $display("FAIL bis_counts: got fe=%0d sc=%0d expected 1/1", fe_o[0], sc_o[0]);
        end
        cycle();
        checks++;
        if (ctl(0) !== 5'b11000 || sc_o[0] !== 16'd1) begin
            errors++;
            $display("FAIL bis_after: got ctl=%b sc=%0d expected 11000/1", ctl(0), sc_o[0]);
        end
    endtask

    task automatic test_forward();
        idle_inputs();
        mem_rd = 5; wb_rd = 5; id_rt = 5; mem_reg_write = 1; wb_reg_write = 1;
        #1;
        checks++;
        if (fb_o[0] !== 2'b10) begin
            errors++;
            $display("FAIL fwd_mem_prio: got %b expected 10", fb_o[0]);
        end
        mem_reg_write = 0;
        #1;
        checks++;
        if (fb_o[0] !== 2'b01) begin
            errors++;
            $display("FAIL fwd_wb: got %b expected 01", fb_o[0]);
        end
        mem_reg_write = 1; id_rt = 0; mem_rd = 0; wb_rd = 0;
        #1;
        checks++;
        if (fb_o[0] !== 2'b00) begin
            errors++;
            $display("FAIL fwd_zero: got %b expected 00", fb_o[0]);
        end
        // forwarding stays live while a load-use stall is being signalled
        mem_rd = 9; id_rs = 9; id_rt = 2; wb_rd = 2;
        ex_mem_read = 1; ex_rd = 9; id_rs_used = 1;
        #1;
        checks++;
        if (fa_o[0] !== 2'b10 || fb_o[0] !== 2'b01 || idexf_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL fwd_during_stall: got fa=%b fb=%b idexf=%b expected 10/01/1",
                     fa_o[0], fb_o[0], idexf_o[0]);
        end
        idle_inputs();
        #1;
    endtask

    task automatic test_zero_reg();
        idle_inputs();
        ex_mem_read = 1; ex_rd = 0; id_rs = 0; id_rs_used = 1; id_rt = 0; id_rt_used = 1;
        mem_reg_write = 1; wb_reg_write = 1;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ctl(i) !== 5'b11000 || fa_o[i] !== 2'b00) begin
                errors++;
                $display("FAIL zero_reg inst%0d: got ctl=%b fa=%b expected 11000/00", i, ctl(i), fa_o[i]);
            end
        end
        idle_inputs();
        #1;
    endtask

    task automatic test_reset_mid_flush();
        do_reset();
        branch_taken = 1;
        #1;
        cycle();
        branch_taken = 0;
        #1;
        checks++;
        if (ctl(0) !== 5'b11101 || fe_o[0] !== 16'd1) begin
            errors++;
            $display("FAIL rmf_in_flush: got ctl=%b fe=%0d expected 11101/1", ctl(0), fe_o[0]);
        end
        rst = 1;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ctl(i) !== 5'b11000 || sc_o[i] !== 16'd0 || fe_o[i] !== 16'd0) begin
                errors++;
                $display("FAIL rmf_reset inst%0d: got ctl=%b sc=%0d fe=%0d expected 11000/0/0",
                         i, ctl(i), sc_o[i], fe_o[i]);
            end
        end
        cycle();
        rst = 0;
        #1;
        checks++;
        if (ctl(0) !== 5'b11000) begin
            errors++;
            $display("FAIL rmf_release: got %b expected 11000", ctl(0));
        end
        cycle();
        checks++;
        if (ctl(0) !== 5'b11000) begin
            errors++;
            $display("FAIL rmf_no_residue: got %b expected 11000", ctl(0));
        end
    endtask

    task automatic test_saturation();
        do_reset();
        ex_mem_read = 1; ex_rd = 3; id_rt = 3; id_rt_used = 1;
        #1;
        for (int c = 0; c < 20; c++) begin
            cycle();
            if (c == 14) begin
                checks++;
                if (sc_o[1] !== 16'd15) begin
                    errors++;
                    $display("FAIL sat_reach: got %0d expected 15", sc_o[1]);
                end
            end
        end
        idle_inputs();
        #1;
        checks++;
        if (sc_o[1] !== 16'd15) begin
            errors++;
            $display("FAIL sat_hold: got %0d expected 15", sc_o[1]);
        end
        checks++;
        if (sc_o[0] !== 16'd20 || sc_o[2] !== 16'd20) begin
            errors++;
            $display("FAIL sat_wide: got %0d/%0d expected 20/20", sc_o[0], sc_o[2]);
        end
        repeat (3) cycle();
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            id_rs         = 5'($urandom_range(0, 3));
            id_rt         = 5'($urandom_range(0, 3));
            ex_rd         = 5'($urandom_range(0, 3));
            mem_rd        = 5'($urandom_range(0, 3));
            wb_rd         = 5'($urandom_range(0, 3));
            id_rs_used    = 1'($urandom_range(0, 1));
            id_rt_used    = 1'($urandom_range(0, 1));
            ex_reg_write  = 1'($urandom_range(0, 1));
            ex_mem_read   = 1'($urandom_range(0, 1));
            mem_reg_write = 1'($urandom_range(0, 1));
            wb_reg_write  = 1'($urandom_range(0, 1));
            branch_taken  = ($urandom_range(0, 7) == 0);
            rst           = ($urandom_range(0, 63) == 0);
            #1;
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (ctl(i) !== exp_ctl(i)) begin
                    errors++;
                    $display("FAIL rand_ctl n%0d inst%0d: got %b expected %b", n, i, ctl(i), exp_ctl(i));
                end
                checks++;
                if (fa_o[i] !== exp_fwd(id_rs) || fb_o[i] !== exp_fwd(id_rt)) begin
                    errors++;
                    $display("FAIL rand_fwd n%0d inst%0d: got %b/%b expected %b/%b",
                             n, i, fa_o[i], fb_o[i], exp_fwd(id_rs), exp_fwd(id_rt));
                end
                checks++;
                if (rst == 1'b0 && (sc_o[i] !== 16'(m_sc[i]) || fe_o[i] !== 16'(m_fe[i]))) begin
                    errors++;
                    $display("FAIL rand_cnt n%0d inst%0d: got sc=%0d fe=%0d expected %0d/%0d",
                             n, i, sc_o[i], fe_o[i], m_sc[i], m_fe[i]);
                end
            end
            cycle();
        end
        rst = 0;
        idle_inputs();
        #1;
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            m_stall[i] = 0; m_flush[i] = 0; m_sc[i] = 0; m_fe[i] = 0;
        end
        @(negedge clk);
        #1;
        test_reset();
        test_load_use();
        test_branch_in_stall();
        test_forward();
        test_zero_reg();
        test_reset_mid_flush();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_unit.md
HAZARD_CTRL_UNIT -- requirements
Module: hazard_ctrl_unit

Interface
REQ-001 Parameter REG_ADDR_W, default 5, SHALL set the register-address width.
REQ-002 Parameter LOAD_STALL_CYCLES, default 1, range 1..3, SHALL set the number of bubble cycles inserted per load-use hazard.
REQ-003 Parameter FLUSH_CYCLES, default 1, range 1..2, SHALL set the number of IF/ID flush cycles per taken branch or jump.
REQ-004 Parameter CNT_W, default 16, SHALL set the performance-counter width.
REQ-005 Ports SHALL be as follows:
- clk  in  1  sole clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_rs, id_rt  in  REG_ADDR_W  source register addresses of the instruction in ID.
- id_rs_used, id_rt_used  in  1  the ID instruction actually reads rs / rt.
- ex_rd  in  REG_ADDR_W  destination register of the instruction in EX.
- ex_reg_write, ex_mem_read  in  1  the EX instruction writes a register / is a load.
- mem_rd  in  REG_ADDR_W  destination register of the instruction in MEM.
- mem_reg_write  in  1  the MEM instruction writes a register.
- wb_rd  in  REG_ADDR_W  destination register of the instruction in WB.
- wb_reg_write  in  1  the WB instruction writes a register.
- branch_taken  in  1  taken branch or jump resolved this cycle.
- pc_write_en, ifid_write_en  out  1  PC / IF-ID register update enables.
- ifid_flush, idex_flush  out  1  IF-ID / ID-EX bubble insertion.
- fwd_a, fwd_b  out  2  operand select: 00 register file, 01 WB, 10 MEM.
- stall_active  out  1  FSM is in the STALL or FLUSH state.
- stall_cycles, flush_events  out  CNT_W  saturating performance counters.

Function
REQ-006 A load-use hazard SHALL be detected when ex_mem_read=1, ex_rd!=0, and ((id_rs_used and ex_rd==id_rs) or (id_rt_used and ex_rd==id_rt)).
REQ-007 The FSM SHALL have three states, RUN, STALL and FLUSH, with RUN as the reset state.
REQ-008 In RUN, a detected hazard SHALL drive pc_write_en=0, ifid_write_en=0 and idex_flush=1 in that same cycle (combinational).
- Next state is STALL with count=LOAD_STALL_CYCLES-1 if LOAD_STALL_CYCLES>1, otherwise RUN.
REQ-009 In STALL, the outputs of REQ-008 SHALL be held while count decrements each cycle; at count==1 the next state is RUN.
- Total bubbles per hazard are exactly LOAD_STALL_CYCLES.
REQ-010 branch_taken=1 SHALL take priority over any stall in any state, in the same cycle:
- ifid_flush=1 and idex_flush=1.
- pc_write_en=1 and ifid_write_en=1.
- A pending stall is abandoned.
- Next state is FLUSH with count=FLUSH_CYCLES-1 if FLUSH_CYCLES>1, else RUN.
REQ-011 In FLUSH, the FSM SHALL assert ifid_flush=1 only and return to RUN when count reaches 0; a new branch_taken in FLUSH SHALL restart the FLUSH count.
REQ-012 With no hazard and no branch, outputs SHALL be pc_write_en=1, ifid_write_en=1, ifid_flush=0 and idex_flush=0.
REQ-013 fwd_a SHALL be selected as follows (fwd_b identically with id_rt):
- 10 if mem_reg_write and mem_rd!=0 and mem_rd==id_rs.
- Else 01 if wb_reg_write and wb_rd!=0 and wb_rd==id_rs.
- Else 00.
- MEM has priority when MEM and WB both match.
- Forward selects are combinational and are not gated by stall.
REQ-014 stall_cycles SHALL increment by 1 on every cycle in which idex_flush is asserted due to a load-use stall; flush_events SHALL increment by 1 per branch_taken cycle; both counters saturate at all-ones and never wrap.
REQ-015 Register address 0 SHALL never cause a stall or a forward.

Reset
REQ-016 rst=1 SHALL asynchronously force:
- state RUN, count 0.
- stall_cycles=0 and flush_events=0.
- pc_write_en=1, ifid_write_en=1, ifid_flush=0, idex_flush=0, stall_active=0.
REQ-017 Reset asserted in the middle of a STALL or FLUSH SHALL abandon it, with no residual bubble after release.

Structure
REQ-018 Package hazard_pkg SHALL hold the state enum (RUN/STALL/FLUSH) and the fwd-select constants FWD_RF=00, FWD_WB=01 and FWD_MEM=10.
REQ-019 The forwarding compare SHALL be one sub-module, fwd_select, instantiated twice (operand A and operand B); the FSM and counters reside in the top module.

Verification
REQ-020 Load-use, LOAD_STALL_CYCLES=2: ex_mem_read=1, ex_rd=8, id_rs=8, id_rs_used=1 -> pc_write_en=0 and idex_flush=1 for exactly 2 cycles; then stall_cycles=2.
REQ-021 Branch during stall: hazard as in REQ-020, branch_taken=1 on the second stall cycle -> ifid_flush=idex_flush=1 and pc_write_en=1 that cycle; flush_events=1; no further stall cycle.
REQ-022 Forward priority: mem_rd=wb_rd=id_rt=5 with both write enables set -> fwd_b=10; with mem_reg_write=0 -> fwd_b=01; with id_rt=0 -> fwd_b=00.
REQ-023 Zero register: ex_mem_read=1, ex_rd=0, id_rs=0 -> no stall, pc_write_en=1.
REQ-024 Reset mid-operation: rst pulsed during a FLUSH with FLUSH_CYCLES=2 -> all outputs at reset values immediately and both counters 0.
REQ-025 Saturation: with CNT_W=4, 20 back-to-back hazards at LOAD_STALL_CYCLES=1 -> stall_cycles holds at 15.
